// File: rtl/instruction_line_memory.sv
// Backing instruction store: 256 x 16 word array serving 64-bit line refills
// to the instruction cache, plus a preload port that is live in every state.
module instruction_line_memory #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        memory_read_enable,
  input  logic [5:0]  memory_address,
  output logic        memory_read_ready,
  output logic [63:0] memory_data,
  input  logic        load_enable,
  input  logic [7:0]  load_address,
  input  logic [15:0] load_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FETCH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LAT = 4'(LATENCY);

  logic [15:0] mem_q [0:255];
  state_t      state_q;
  logic [5:0]  req_line_q;
  logic [3:0]  wait_count_q;
  logic [1:0]  beat_q;
  logic        ready_q;
  logic [63:0] data_q;
  logic [15:0] fetch_word_s;

  // The array has no reset; a beat reads the value from before any same-edge load.
  assign fetch_word_s = mem_q[{req_line_q, beat_q}];

  // Preload write port, independent of the refill FSM and of reset.
  always_ff @(posedge clock) begin
    if (load_enable) begin
      mem_q[load_address] <= load_data;
    end
  end

  // Refill FSM: latch the request, wait LATENCY cycles, fetch four beats, pulse ready.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      req_line_q   <= 6'd0;
      wait_count_q <= 4'd0;
      beat_q       <= 2'd0;
      ready_q      <= 1'b0;
      data_q       <= 64'd0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (memory_read_enable) begin
            req_line_q <= memory_address;
            beat_q     <= 2'd0;
            if (LAT != 4'd0) begin
              state_q      <= WAIT;
              wait_count_q <= LAT;
            end else begin
              state_q      <= FETCH;
              wait_count_q <= 4'd0;
            end
          end
        end
        WAIT: begin
          wait_count_q <= wait_count_q - 4'd1;
          if (wait_count_q == 4'd1) begin
            state_q <= FETCH;
            beat_q  <= 2'd0;
          end
        end
        FETCH: begin
          data_q[{beat_q, 4'b0000} +: 16] <= fetch_word_s;
          beat_q <= beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_q <= DONE;
            ready_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign memory_read_ready = ready_q;
  assign memory_data       = data_q;

endmodule

// File: doc/instruction_line_memory.md
# instruction_line_memory

Backing instruction store serving 64-bit line refills for the 2-way instruction cache. Accepts a one-cycle line request (6-bit line address), fetches the four 16-bit words of that line sequentially from a 256 x 16 word array after a programmable latency, then presents the assembled line with a one-cycle ready pulse. A separate load port preloads program words from the testbench or boot logic.

## Interface
- LATENCY, 2, extra wait cycles between request capture and the first word fetch (0..15)
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- memory_read_enable  input  1  line request strobe from cache; one cycle wide
- memory_address  input  6  line address {tag, line index}; sampled only with the strobe
- memory_read_ready  output  1  one-cycle pulse; memory_data valid in this cycle
- memory_data  output  64  assembled line; word w at bits [16w+15:16w]
- load_enable  input  1  write one word into the array
- load_address  input  8  word address {line[5:0], word[1:0]}
- load_data  input  16  word to write

## Operation
- Storage: 256 words x 16 bits; word address = {line address, word index}. Array not cleared by reset.
- States: IDLE, WAIT, FETCH, DONE.
- IDLE: memory_read_enable=1 at an edge -> latch memory_address into req_line; LATENCY>0 -> WAIT with wait_count=LATENCY; LATENCY=0 -> FETCH with beat=0.
- WAIT: wait_count decrements each edge; edge with wait_count==1 -> FETCH, beat=0.
- FETCH: each edge writes array[{req_line,beat}] into line buffer slice [16*beat+15:16*beat], beat increments; edge with beat==3 -> DONE.
- DONE: memory_read_ready=1 for exactly this cycle; memory_data = full new line; next edge -> IDLE.
- memory_data is registered; updates only on FETCH beats; holds last line until the next fetch overwrites it. Beat slices update progressively during FETCH; only the DONE cycle is guaranteed coherent.
- memory_read_enable in WAIT, FETCH or DONE: ignored, no queueing (cache never issues one while it waits).
- memory_address while not in IDLE: ignored; fetch uses latched req_line only.
- Load port: active in every state, including during reset; load_enable=1 writes load_data at load_address on the edge.
- Load/fetch collision on the same word at the same edge: the beat captures the pre-write value; the new value is seen by later fetches.

## Timing
- Reset values: memory_read_ready=0, memory_data=64'h0, state=IDLE, wait_count=0, beat=0.
- Reset asserted mid-operation: next edge forces IDLE, drops any pending request, clears memory_data; no ready pulse for the aborted request.
- Request strobe high in cycle 0 -> memory_read_ready high in cycle LATENCY+5 (cycle 7 at default, cycle 5 at LATENCY=0), low in all other cycles.
- memory_read_ready never high for two consecutive cycles.
- Earliest next accepted request: cycle LATENCY+6 (first IDLE cycle after DONE).
- memory_read_ready and memory_data come straight from registers (no combinational path from inputs); the cache consumes them combinationally in its WAIT state.

## Test plan
- Reset, then hold: memory_read_ready=0 and memory_data=0 for 10 cycles with no request.
- Load words 0x1000..0x1003 at word addresses 0x14..0x17, strobe request with line 6'h05 in cycle 0 (LATENCY=2) -> ready only in cycle 7, memory_data=64'h1003_1002_1001_1000.
- LATENCY=0 build, request line 6'h3F preloaded with 0xAAAA,0xBBBB,0xCCCC,0xDDDD -> ready in cycle 5, data 64'hDDDD_CCCC_BBBB_AAAA; data holds after the pulse.
- Extra strobe with line 6'h01 in cycle 3 during the line-5 fetch -> single ready pulse in cycle 7 with line-5 data; no second pulse.
- Load 0xBEEF to word 0x16 on the same edge that beat 2 of line 5 reads it -> returned word 2 = old value 0x1002; a repeat request returns 0xBEEF.
- Reset asserted in cycle 4 of a fetch -> no ready pulse; memory_data=0; next request returns correct data with normal LATENCY+5 latency.
